// File: rtl/stage_queue_pkg.sv
// Shared parameters for the inter-stage elastic queue.
// XLEN sets the default payload width of the core datapath.
package stage_queue_pkg;

  localparam int XLEN = 32;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stage_queue.sv
// Elastic buffer between two pipeline stages using stall-polarity handshakes.
// Registered-state status outputs, one-cycle flush, no fall-through or bypass.
module stage_queue
  import stage_queue_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        prev_stalled,
  output logic                        stall_prev,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        next_stalled,
  output logic                        stall_next,
  output logic [occ_width(DEPTH)-1:0] count,
  output logic                        almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             almost_full_q, almost_full_d;
  logic             push, pop;

  assign stall_prev  = (count_q == CW'(DEPTH));
  assign stall_next  = (count_q == '0);
  assign push        = !prev_stalled && !stall_prev;
  assign pop         = !next_stalled && !stall_next;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = almost_full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    almost_full_d = (count_d >= CW'(AFULL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is deliberately unreset so it maps onto LUTRAM with async read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) push |-> !stall_prev);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) pop |-> !stall_next);
  a_count_range:  assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_stage_queue.sv
// Scoreboard bench for stage_queue: an occupancy/queue model tracks accepted
// data, a negedge monitor pops and compares whenever the queue presents output.
module tb_stage_queue;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         prev_stalled;
  logic         stall_prev;
  logic [W-1:0] out_data;
  logic         next_stalled;
  logic         stall_next;
  logic [2:0]   count;
  logic         almost_full;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] sb_q[$];
  int           m_cnt = 0;

  stage_queue #(.WIDTH(W), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .prev_stalled(prev_stalled), .stall_prev(stall_prev), .out_data(out_data),
    .next_stalled(next_stalled), .stall_next(stall_next), .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a queue of accepted words and an occupancy number.
  initial begin
    bit m_push, m_pop;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_cnt = 0;
        sb_q.delete();
      end else if (flush) begin
        m_cnt = 0;
        sb_q.delete();
      end else begin
        m_push = !prev_stalled && (m_cnt < DEPTH);
        m_pop  = !next_stalled && (m_cnt > 0);
        if (m_push) sb_q.push_back(in_data);
        m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Monitor: status compared every cycle, payload popped on each pop handshake.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("count", 32'(count), 32'(m_cnt));
        check("stall_next", 32'(stall_next), 32'(m_cnt == 0));
        check("stall_prev", 32'(stall_prev), 32'(m_cnt == DEPTH));
        check("almost_full", 32'(almost_full), 32'(m_cnt >= AFULL));
        if (!stall_next && !next_stalled) begin
          if (sb_q.size() == 0) begin
            check("underflow", 32'(out_data), 32'hDEAD_BEEF);
          end else begin
            exp = sb_q.pop_front();
            check("out_data", 32'(out_data), 32'(exp));
          end
        end
      end
    end
  end

  task automatic step(input bit pv, input logic [W-1:0] d, input bit ns, input bit fl);
    prev_stalled = pv;
    in_data      = d;
    next_stalled = ns;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_stall_next"}, 32'(stall_next), 1);
    check({tag, "_stall_prev"}, 32'(stall_prev), 0);
    check({tag, "_almost_full"}, 32'(almost_full), 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; prev_stalled = 1'b1; next_stalled = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
    repeat (3) step(1, 8'h00, 0, 0);

    // Fill with downstream stalled; fifth value held off while full.
    for (int i = 0; i < 4; i++) step(0, 8'hA0 + 8'(i), 1, 0);
    check("fill_count", 32'(count), 4);
    check("fill_stall_prev", 32'(stall_prev), 1);
    repeat (2) step(0, 8'hA4, 1, 0);
    repeat (5) step(1, 8'h00, 0, 0);
    check("drained_stall_next", 32'(stall_next), 1);

    // Pop at full with a push offered: accepted only on the following cycle.
    for (int i = 0; i < 4; i++) step(0, 8'hB0 + 8'(i), 1, 0);
    step(0, 8'hB4, 0, 0);
    check("pop_full_count", 32'(count), 3);
    step(0, 8'hB4, 1, 0);
    check("refill_count", 32'(count), 4);
    repeat (5) step(1, 8'h00, 0, 0);

    // Simultaneous push/pop at count 2.
    step(0, 8'hC0, 1, 0);
    step(0, 8'hC1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'hC2 + 8'(i), 0, 0);
    check("pushpop_count", 32'(count), 2);
    repeat (3) step(1, 8'h00, 0, 0);

    // Flush at count 3 while both handshakes fire; 0x55 must come out first.
    for (int i = 0; i < 3; i++) step(0, 8'hD0 + 8'(i), 1, 0);
    step(0, 8'h77, 0, 1);
    check_reset_outputs("flush");
    step(0, 8'h55, 1, 0);
    check("post_flush_head", 32'(out_data), 32'h55);
    repeat (2) step(1, 8'h00, 0, 0);

    // Streaming: occupancy sits at one, pointers wrap many times.
    for (int i = 0; i < 100; i++) step(0, 8'(i), 0, 0);
    check("stream_count", 32'(count), 1);
    repeat (2) step(1, 8'h00, 0, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 49) == 0));

    // Async reset mid-stream, away from any clock edge.
    step(0, 8'hE0, 1, 0);
    step(0, 8'hE1, 1, 0);
    step(0, 8'hE2, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 8'h3C, 1, 0);
    repeat (3) step(1, 8'h00, 0, 0);
    check("final_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_queue.md
# stage_queue

Parametrised elastic buffer inserted between two pipeline stages of the core, e.g. between `ifetch` and `decode` as a prefetch queue. It speaks the core's stall-polarity handshake on both sides and holds up to `DEPTH` entries so the upstream stage can run ahead of a stalled downstream stage. A pipeline flush empties it in one cycle. Occupancy and almost-full status are exported for fetch throttling and debug.

## Interface
- `WIDTH`, default `` `XLEN ``: payload width in bits. Any value ≥1.
- `DEPTH`, default 4: entry count. Must be a power of two, ≥2.
- `AFULL`, default `DEPTH-1`: `almost_full` threshold, 1..DEPTH.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  synchronous discard of all contents.
- `in_data`  in  WIDTH  upstream payload.
- `prev_stalled`  in  1  high = `in_data` not valid.
- `stall_prev`  out  1  high = block cannot accept input.
- `out_data`  out  WIDTH  head-of-queue payload.
- `next_stalled`  in  1  high = downstream cannot accept.
- `stall_next`  out  1  high = `out_data` not valid.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `almost_full`  out  1  high when `count >= AFULL`.

## Operation
- Push handshake: `!prev_stalled && !stall_prev`. Pop handshake: `!stall_next && !next_stalled`.
- `stall_prev = (count == DEPTH)`. `stall_next = (count == 0)`. Both are functions of registered state only. There is no combinational path from `next_stalled` or `prev_stalled` to any output.
- Storage: `DEPTH`×`WIDTH` array, not reset. Write pointer and read pointer are `$clog2(DEPTH)` bits and wrap modulo DEPTH without special-casing.
- `out_data = mem[rd_ptr]`. It is undefined while `stall_next` is high; checkers must ignore it then.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full: push is impossible because `stall_prev` is high. A pop while full frees a slot, and input is accepted from the next cycle. There is no same-cycle bypass when full.
- Empty: no pop is possible. Data pushed while empty appears at `out_data` with `stall_next` low on the following cycle. There is no fall-through.
- Flush has priority over everything. In a flush cycle:
  - any push or pop handshake occurring in that cycle is discarded;
  - pointers and count clear at the edge.
- Flush while empty is a no-op. Flush and reset have identical end states.
- Reset mid-operation: contents are lost immediately and outputs take their reset values asynchronously.

## Timing
- Reset values: `stall_prev`=0, `stall_next`=1, `count`=0, `almost_full`=0, pointers=0.
- Latency: 1 cycle from push acceptance to visibility at output.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- After a flush edge: `stall_next`=1, `stall_prev`=0, `count`=0 on the next cycle.
- `almost_full` and `count` are registered-state derived and update on the same edge as the pointers.

## Structure
- No new package types. `WIDTH` defaults from `XLEN` in `params.svh`.
- Single module, no sub-module. Storage is an inferred array (distributed RAM/LUTRAM friendly, asynchronous read).
- Assertions, active only while `rst` is high:
  - never push when `stall_prev`;
  - never pop when `stall_next`;
  - `count <= DEPTH`.

## Test plan
- Reset then idle: `rst` low then high, `prev_stalled`=1 → `stall_next`=1, `stall_prev`=0, `count`=0 every cycle.
- Fill/drain, DEPTH=4, `next_stalled`=1: push 0xA0..0xA3 → after the 4th push `count`=4 and `stall_prev`=1; the 5th value is held off. Release `next_stalled` → outputs 0xA0, 0xA1, 0xA2, 0xA3 in order, then `stall_next`=1.
- Streaming: both sides always ready, push 100 incrementing values → output matches in order with one-cycle latency, `count` stays 1, pointers wrap 25 times.
- Simultaneous push/pop at count=2 → `count` stays 2. Pop at full (4) with a push offered → same cycle `count`→3, push accepted the next cycle.
- Flush with count=3 while push and pop handshakes are both active → next cycle `count`=0 and `stall_next`=1. The next pushed value 0x55 is the first output.
- AFULL=3: push to count 3 → `almost_full`=1; pop to 2 → `almost_full`=0. Assert `rst` low mid-stream → all outputs return to reset values without a clock edge.
